com_to_in: RTL and testbench
============================

COM_TO_IN -- requirements
Module: com_to_in

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- OVERSAMPLE, 16, enable ticks per bit period; even, at least 4.
- PARITY_ODD, 0, 0 selects even parity (parity bit = XOR of data bits); 1 selects odd parity.

REQ-002 The block SHALL have these ports (name  direction  width  meaning):
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  oversample tick, one clk wide; sampling logic advances only when high.
- rx  input  1  serial line; idles high.
- ack  input  1  consumer acknowledge; clears valid and the held flags.
- data  output  8  last received byte.
- valid  output  1  data and flags held and unread.
- par_err  output  1  parity mismatch in the held frame.
- frame_err  output  1  stop bit sampled low in the held frame.
- overrun  output  1  a frame completed while valid=1 and ack=0.
- busy  output  1  high in every state except IDLE.

Function
REQ-003 rx SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value (rxs).
REQ-004 Frame format SHALL be: start (0), 8 data bits LSB first, parity bit, stop (1).
REQ-005 States SHALL be IDLE, START, DATA, PARITY, STOP and BREAK; an internal tick counter SHALL run 0..OVERSAMPLE-1.
REQ-006 IDLE: on an enable tick with rxs=0, go to START and clear the counter.
REQ-007 START: on the tick where the counter reaches OVERSAMPLE/2-1, sample rxs.
- rxs=1: false start; return to IDLE with no output change.
- rxs=0: go to DATA and clear the counter and bit index.
REQ-008 DATA: every OVERSAMPLE ticks, sample rxs into shift bit[index] (mid-bit); after index 7, go to PARITY.
REQ-009 PARITY: sample after OVERSAMPLE ticks, then go to STOP.
REQ-010 STOP: sample after OVERSAMPLE ticks.
- rxs=1: go to IDLE.
- rxs=0: go to BREAK.
REQ-011 BREAK: stay until an enable tick sees rxs=1, then go to IDLE.
REQ-012 Completion SHALL be the rising edge after the stop-bit sampling tick. On completion:
- data SHALL be loaded with the shift register.
- par_err SHALL be set to (XOR of data ^ parity bit ^ PARITY_ODD).
- frame_err SHALL be set to the inverse of the stop sample.
- valid SHALL be set to 1.
REQ-013 valid SHALL hold until ack=1 is seen with no completion in the same cycle; then valid, par_err, frame_err and overrun SHALL clear and data SHALL hold.
REQ-014 Completion while valid=1 and ack=0 SHALL overwrite data, par_err and frame_err and SHALL set overrun; overrun SHALL then stick until acked.
REQ-015 Completion and ack in the same cycle: the completion SHALL win, valid SHALL stay 1, and overrun SHALL NOT be set.
REQ-016 With enable=0, the counter, state and shift register SHALL freeze; ack handling SHALL still operate every clk.
REQ-017 ack with valid=0 SHALL have no effect.

Reset
REQ-018 rst_n=0 SHALL immediately set:
- state to IDLE;
- counter, bit index and shift register to 0;
- both synchronizer flops to 1;
- data to 8'h00;
- valid, par_err, frame_err, overrun and busy to 0.
REQ-019 Reset asserted mid-frame SHALL abandon the frame with no completion. After release, the block SHALL wait for a fresh start edge.

Verification
REQ-020 Byte 0xA5, even parity, enable=1 every clk, 16 clk per bit:
- line bits 0,1,0,1,0,0,1,0,1,0,1.
- Required: valid=1, data=0xA5, par_err=0, frame_err=0, overrun=0.
- valid SHALL rise 3 clk after the stop bit's mid-sample point (2 clk synchronizer + 1 clk completion).
REQ-021 Byte 0x01 sent with parity bit 0 (wrong for even parity) -> data=0x01, par_err=1. Sending it again with PARITY_ODD=1 -> par_err=0.
REQ-022 Low glitch of 5 ticks on an idle line -> no state exit from IDLE past START, busy returns to 0, valid stays 0.
REQ-023 Byte 0x3C with the stop bit held 0 for 40 ticks -> frame_err=1, state BREAK; after rx returns high, a following 0x55 frame is received correctly.
REQ-024 Two back-to-back frames 0x11 and 0x22 without ack -> data=0x22, overrun=1. Then:
- an ack pulse -> valid=0, overrun=0;
- ack in the same clk as a completion -> valid stays 1, overrun=0.
REQ-025 rst_n pulsed low during data bit 4 -> all outputs 0 immediately, no valid; the next complete frame 0xF0 -> data=0xF0.

Source files
------------

// File: rtl/com_to_in.sv
// com_to_in : oversampled asynchronous serial receiver.
//
// Frame on rx: start (0), 8 data bits LSB first, parity, stop (1).
// The line is brought into clk through a 2-flop synchronizer. The bit
// timing advances only on enable ticks, with OVERSAMPLE ticks per bit.
// A received byte is held together with its error flags until the
// consumer acknowledges it.
//
// Parameters
//   OVERSAMPLE : enable ticks per bit period (even, >= 4)
//   PARITY_ODD : 0 = even parity, 1 = odd parity
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   enable    in   oversample tick, one clk wide
//   rx        in   serial line, idles high
//   ack       in   consumer acknowledge
//   data      out  last received byte
//   valid     out  data and flags held and unread
//   par_err   out  parity mismatch in the held frame
//   frame_err out  stop bit sampled low in the held frame
//   overrun   out  a frame completed while the previous one was unread
//   busy      out  receiver is not idle
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line idle, waiting for a tick that sees rxs low
// START  | half a bit into the start bit, then confirm it is still low
// DATA   | sample 8 data bits at mid-bit, LSB first
// PARITY | sample the parity bit
// STOP   | sample the stop bit; low stop means a break follows
// BREAK  | line held low after a bad stop bit, wait for it to go high

module com_to_in #(
   parameter int OVERSAMPLE = 16,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       rx,
   input  logic       ack,
   output logic [7:0] data,
   output logic       valid,
   output logic       par_err,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int CNT_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             par_q, par_d;
   logic             stop_q, stop_d;
   logic             done_q, done_d;

   logic             rx_meta_q, rxs_q;

   logic [7:0]       data_q;
   logic             valid_q, par_err_q, frame_err_q, overrun_q;

   // Synchronizer flops reset to the idle level so a reset never looks
   // like a start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rxs_q     <= rx_meta_q;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         stop_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         stop_q  <= stop_d;
         done_q  <= done_d;
      end
   end

   // Next-state and sampling datapath; everything here is frozen
   // while enable is low.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      par_d   = par_q;
      stop_d  = stop_q;
      done_d  = 1'b0;
      if (enable) begin
         case (state_q)
            S_IDLE: begin
               if (!rxs_q) begin
                  state_d = S_START;
                  cnt_d   = '0;
               end
            end
            S_START: begin
               if (cnt_q == CNT_HALF) begin
                  if (rxs_q) begin
                     state_d = S_IDLE;
                  end else begin
                     state_d = S_DATA;
                     cnt_d   = '0;
                     idx_d   = '0;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_DATA: begin
               if (cnt_q == CNT_LAST) begin
                  shift_d[idx_q] = rxs_q;
                  cnt_d          = '0;
                  if (idx_q == 3'd7) begin
                     state_d = S_PARITY;
                  end else begin
                     idx_d = idx_q + 3'd1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_PARITY: begin
               if (cnt_q == CNT_LAST) begin
                  par_d   = rxs_q;
                  cnt_d   = '0;
                  state_d = S_STOP;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_STOP: begin
               if (cnt_q == CNT_LAST) begin
                  stop_d  = rxs_q;
                  done_d  = 1'b1;
                  cnt_d   = '0;
                  state_d = rxs_q ? S_IDLE : S_BREAK;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_BREAK: begin
               if (rxs_q) begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Output decode
   always_comb begin
      busy = (state_q != S_IDLE);
   end

   // Result holding registers. The completion lands one clk after the
   // stop sample regardless of enable; ack is honoured on every clk.
   // A completion always wins over an ack in the same cycle, and that
   // ack still consumes the previous frame, so no overrun is flagged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q      <= 8'h00;
         valid_q     <= 1'b0;
         par_err_q   <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else if (done_q) begin
         data_q      <= shift_q;
         par_err_q   <= ^shift_q ^ par_q ^ PARITY_ODD;
         frame_err_q <= ~stop_q;
         overrun_q   <= (overrun_q | valid_q) & ~ack;
         valid_q     <= 1'b1;
      end else if (ack && valid_q) begin
         valid_q     <= 1'b0;
         par_err_q   <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign par_err   = par_err_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_com_to_in.sv
// tb_com_to_in : bench for com_to_in. Two receivers (even and odd
// parity) watch the same line; a tick-offset model of the frame timing
// predicts every output on every clk, and directed frames pin the model
// with literal expectations.

module tb_com_to_in;

   localparam int OS   = 16;
   localparam int HALF = OS / 2;

   logic clk = 1'b0;
   logic rst_n, enable, rx, ack;

   logic [7:0] data_e, data_o;
   logic valid_e, pe_e, fe_e, ov_e, busy_e;
   logic valid_o, pe_o, fe_o, ov_o, busy_o;

   always #5 clk = ~clk;

   com_to_in #(.OVERSAMPLE(OS), .PARITY_ODD(1'b0)) dut_even (
      .clk(clk), .rst_n(rst_n), .enable(enable), .rx(rx), .ack(ack),
      .data(data_e), .valid(valid_e), .par_err(pe_e), .frame_err(fe_e),
      .overrun(ov_e), .busy(busy_e));

   com_to_in #(.OVERSAMPLE(OS), .PARITY_ODD(1'b1)) dut_odd (
      .clk(clk), .rst_n(rst_n), .enable(enable), .rx(rx), .ack(ack),
      .data(data_o), .valid(valid_o), .par_err(pe_o), .frame_err(fe_o),
      .overrun(ov_o), .busy(busy_o));

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Line seen by the receiver is rx delayed two clks. A frame is
   // described by the number of enable ticks since the start edge was
   // first seen: start confirm at HALF, then bit k sampled at HALF+k*OS.
   logic       m_s1 = 1'b1, m_s2 = 1'b1, m_r;
   int         m_mode = 0;   // 0 idle, 1 in frame, 2 break
   int         m_off = 0, m_k;
   logic [7:0] m_sh = 8'h00;
   logic       m_par = 1'b0, m_stop = 1'b1, m_pend = 1'b0;
   logic [7:0] m_data = 8'h00;
   logic       m_valid = 1'b0, m_pe_e = 1'b0, m_pe_o = 1'b0, m_fe = 1'b0, m_ov = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_s1 = 1'b1; m_s2 = 1'b1; m_mode = 0; m_off = 0; m_sh = 8'h00;
         m_pend = 1'b0; m_data = 8'h00; m_valid = 1'b0; m_pe_e = 1'b0;
         m_pe_o = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
      end else begin
         m_r  = m_s2;
         m_s2 = m_s1;
         m_s1 = rx;
         if (m_pend) begin
            m_data = m_sh;
            m_pe_e = ^m_sh ^ m_par;
            m_pe_o = ~(^m_sh ^ m_par);
            m_fe   = ~m_stop;
            m_ov   = (m_ov | m_valid) & ~ack;
            m_valid = 1'b1;
            m_pend = 1'b0;
         end else if (ack && m_valid) begin
            m_valid = 1'b0; m_pe_e = 1'b0; m_pe_o = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
         end
         if (enable) begin
            case (m_mode)
               0: if (!m_r) begin m_mode = 1; m_off = 0; end
               1: begin
                  m_off++;
                  if (m_off == HALF && m_r) begin
                     m_mode = 0;
                  end else if (m_off > HALF && (m_off - HALF) % OS == 0) begin
                     m_k = (m_off - HALF) / OS;
                     if (m_k <= 8) m_sh[m_k-1] = m_r;
                     else if (m_k == 9) m_par = m_r;
                     else begin
                        m_stop = m_r;
                        m_pend = 1'b1;
                        m_mode = m_r ? 0 : 2;
                     end
                  end
               end
               default: if (m_r) m_mode = 0;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      chk("cyc_data", data_e, m_data);
      chk("cyc_valid", valid_e, m_valid);
      chk("cyc_par_err", pe_e, m_pe_e);
      chk("cyc_frame_err", fe_e, m_fe);
      chk("cyc_overrun", ov_e, m_ov);
      chk("cyc_busy", busy_e, m_mode != 0);
      chk("cyc_odd_data", data_o, m_data);
      chk("cyc_odd_valid", valid_o, m_valid);
      chk("cyc_odd_par_err", pe_o, m_pe_o);
      chk("cyc_odd_frame_err", fe_o, m_fe);
      chk("cyc_odd_overrun", ov_o, m_ov);
      chk("cyc_odd_busy", busy_o, m_mode != 0);
   end

   // ---------------- stimulus ----------------
   bit rand_en  = 1'b0;
   bit rand_ack = 1'b0;

   // Advance until n enable ticks have been seen; inputs change on negedge.
   task automatic tick_cycles(input int n);
      int c = 0;
      while (c < n) begin
         @(posedge clk);
         if (enable) c++;
         @(negedge clk);
         enable = rand_en ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (rand_ack) ack = ($urandom_range(0, 29) == 0);
      end
   endtask

   task automatic send_head(input logic [7:0] b, input logic p);
      rx = 1'b0;
      tick_cycles(OS);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick_cycles(OS);
      end
      rx = p;
      tick_cycles(OS);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic p, input logic stop_v, input int stop_ticks);
      send_head(b, p);
      rx = stop_v;
      tick_cycles(stop_ticks);
      rx = 1'b1;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      tick_cycles(n);
   endtask

   task automatic ack_pulse();
      ack = 1'b1;
      tick_cycles(1);
      ack = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      logic       p, stop_v;
      int         r;

      rst_n = 1'b0; enable = 1'b1; rx = 1'b1; ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_data", data_e, 8'h00);
      chk("rst_valid", valid_e, 1'b0);
      chk("rst_busy", busy_e, 1'b0);
      chk("rst_overrun", ov_e, 1'b0);
      rst_n = 1'b1;
      idle(30);

      // 0xA5, even parity, enable every clk: valid rises 3 clk after the
      // stop bit's mid point on the line.
      send_head(8'hA5, 1'b0);
      rx = 1'b1;
      tick_cycles(11);
      chk("a5_valid_before", valid_e, 1'b0);
      tick_cycles(1);
      chk("a5_valid", valid_e, 1'b1);
      chk("a5_data", data_e, 8'hA5);
      chk("a5_par_err", pe_e, 1'b0);
      chk("a5_frame_err", fe_e, 1'b0);
      chk("a5_overrun", ov_e, 1'b0);
      chk("model_a5_data", m_data, 8'hA5);
      tick_cycles(4);
      ack_pulse();
      chk("a5_ack_valid", valid_e, 1'b0);
      chk("a5_ack_data_hold", data_e, 8'hA5);

      // 0x01 with wrong even parity (0) is correct odd parity
      send_frame(8'h01, 1'b0, 1'b1, OS);
      idle(4);
      chk("p01_data", data_e, 8'h01);
      chk("p01_even_par_err", pe_e, 1'b1);
      chk("p01_odd_par_err", pe_o, 1'b0);
      chk("model_p01_par_err", m_pe_e, 1'b1);
      ack_pulse();

      // 5-tick glitch: false start
      rx = 1'b0;
      tick_cycles(5);
      chk("glitch_busy_seen", busy_e, 1'b1);
      rx = 1'b1;
      tick_cycles(20);
      chk("glitch_busy_after", busy_e, 1'b0);
      chk("glitch_valid", valid_e, 1'b0);

      // 0x3C with stop held low for 40 ticks, then 0x55
      send_head(8'h3C, 1'b0);
      rx = 1'b0;
      tick_cycles(40);
      chk("brk_frame_err", fe_e, 1'b1);
      chk("brk_busy", busy_e, 1'b1);
      chk("brk_data", data_e, 8'h3C);
      rx = 1'b1;
      tick_cycles(10);
      chk("brk_exit_busy", busy_e, 1'b0);
      ack_pulse();
      send_frame(8'h55, 1'b0, 1'b1, OS);
      idle(4);
      chk("after_brk_data", data_e, 8'h55);
      chk("after_brk_frame_err", fe_e, 1'b0);
      chk("after_brk_valid", valid_e, 1'b1);
      ack_pulse();

      // back-to-back without ack -> overrun
      send_frame(8'h11, 1'b0, 1'b1, OS);
      send_frame(8'h22, 1'b0, 1'b1, OS);
      idle(4);
      chk("ovr_data", data_e, 8'h22);
      chk("ovr_overrun", ov_e, 1'b1);
      chk("model_ovr_overrun", m_ov, 1'b1);
      ack_pulse();
      chk("ovr_ack_valid", valid_e, 1'b0);
      chk("ovr_ack_overrun", ov_e, 1'b0);

      // ack in the same clk as a completion, previous frame unread
      send_frame(8'h33, 1'b0, 1'b1, OS);
      idle(2);
      chk("same_pre_valid", valid_e, 1'b1);
      send_head(8'h44, 1'b0);
      rx = 1'b1;
      tick_cycles(11);
      ack = 1'b1;
      tick_cycles(1);
      ack = 1'b0;
      chk("same_valid", valid_e, 1'b1);
      chk("same_overrun", ov_e, 1'b0);
      chk("same_data", data_e, 8'h44);
      tick_cycles(4);
      ack_pulse();

      // reset during data bit 4
      rx = 1'b0;
      tick_cycles(OS);
      for (int i = 0; i < 4; i++) begin
         rx = r[0];
         rx = (i % 2 == 0);
         tick_cycles(OS);
      end
      rx = 1'b1;
      tick_cycles(8);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_data", data_e, 8'h00);
      chk("midrst_valid", valid_e, 1'b0);
      chk("midrst_busy", busy_e, 1'b0);
      chk("midrst_overrun", ov_e, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(30);
      chk("midrst_no_valid", valid_e, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b1, OS);
      idle(4);
      chk("f0_data", data_e, 8'hF0);
      chk("f0_valid", valid_e, 1'b1);
      ack_pulse();

      // randomized traffic: random enable, random acks
      rand_en  = 1'b1;
      rand_ack = 1'b1;
      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 9);
         b = 8'($urandom);
         if (r == 0) begin
            rx = 1'b0;
            tick_cycles($urandom_range(1, HALF - 4));
            idle(20);
         end else begin
            p      = ^b ^ ($urandom_range(0, 5) == 0);
            stop_v = ($urandom_range(0, 7) != 0);
            send_frame(b, p, stop_v, stop_v ? OS : $urandom_range(OS, 3 * OS));
            if (!stop_v) idle($urandom_range(2, 20));
            else if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 30));
         end
      end
      rand_en  = 1'b0;
      rand_ack = 1'b0;
      ack      = 1'b0;
      enable   = 1'b1;
      idle(200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
